// File: rtl/mvu_job_seq.sv
// Job sequencer for a bank of bit-serial MVU lanes: walks len words per bit plane
// across prec planes, with clear/shift/enable strobes gated by a per-job lane mask.

module mvu_job_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic part_i,
    input  logic clr_i,
    input  logic sh_i,
    input  logic en_i,
    output logic clr_o,
    output logic sh_o,
    output logic en_o
);
    logic clr_q, sh_q, en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q <= 1'b0;
            sh_q  <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            clr_q <= clr_i & part_i;
            sh_q  <= sh_i & part_i;
            en_q  <= en_i & part_i;
        end
    end

    assign clr_o = clr_q;
    assign sh_o  = sh_q;
    assign en_o  = en_q;
endmodule

module mvu_job_seq #(
    parameter int N  = 8,
    parameter int AW = 9,
    parameter int LW = 9,
    parameter int PW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [AW-1:0]   cmd_base,
    input  logic [LW-1:0]   cmd_len,
    input  logic [PW-1:0]   cmd_prec,
    input  logic [1:0]      cmd_mode,
    input  logic [N-1:0]    cmd_mask,
    input  logic            hold,
    input  logic            abort,
    output logic [N-1:0]    clr,
    output logic [N-1:0]    sh,
    output logic [N-1:0]    en,
    output logic [2*N-1:0]  mulmode,
    output logic [AW*N-1:0] raddr,
    output logic            busy,
    output logic            done
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_SHIFT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, raddr_q, raddr_d;
    logic [LW-1:0] len_q, len_d, wcnt_q, wcnt_d;
    logic [PW-1:0] prec_q, prec_d, pcnt_q, pcnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [N-1:0]  mask_q, mask_d;
    logic          done_q, done_d, busy_q, busy_d, rdy_q, rdy_d;
    logic          clr_d, sh_d, en_d;
    logic          issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            raddr_q <= '0;
            len_q   <= '0;
            wcnt_q  <= '0;
            prec_q  <= '0;
            pcnt_q  <= '0;
            mode_q  <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            raddr_q <= raddr_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            prec_q  <= prec_d;
            pcnt_q  <= pcnt_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    // issue = a word is presented to the lanes next cycle; the pointer never
    // rewinds between planes, so planes are laid out back to back in memory.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        prec_d  = prec_q;
        pcnt_d  = pcnt_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        issue   = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_d = S_CLR;
                        ptr_d   = cmd_base;
                        len_d   = cmd_len;
                        prec_d  = (cmd_prec == '0) ? PW'(1) : cmd_prec;
                        mode_d  = cmd_mode;
                        mask_d  = cmd_mask;
                        wcnt_d  = '0;
                        pcnt_d  = '0;
                    end
                end
                S_CLR: begin
                    if (len_q != '0) begin
                        state_d = S_RUN;
                        issue   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        if (wcnt_q != len_q) begin
                            issue = 1'b1;
                        end else if (pcnt_q == prec_q - PW'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SHIFT;
                            pcnt_d  = pcnt_q + PW'(1);
                            wcnt_d  = '0;
                        end
                    end
                end
                S_SHIFT: begin
                    if (!hold) begin
                        state_d = S_RUN;
                        issue   = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        if (issue) begin
            ptr_d  = ptr_q + AW'(1);
            wcnt_d = wcnt_q + LW'(1);
        end
    end

    // Strobes are decoded from the upcoming state so every output leaves a flop.
    always_comb begin
        clr_d   = (state_d == S_CLR);
        sh_d    = (state_q == S_RUN) && (state_d == S_SHIFT);
        en_d    = issue;
        raddr_d = issue ? ptr_q : raddr_q;
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        rdy_d   = (state_d == S_IDLE);
    end

    genvar i;
    for (i = 0; i < N; i++) begin : g_lane
        mvu_job_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .part_i (mask_d[i]),
            .clr_i  (clr_d),
            .sh_i   (sh_d),
            .en_i   (en_d),
            .clr_o  (clr[i]),
            .sh_o   (sh[i]),
            .en_o   (en[i])
        );
        assign mulmode[2*i +: 2]  = mode_q;
        assign raddr[AW*i +: AW] = raddr_q;
    end

    assign cmd_ready = rdy_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
